// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family: FSM encoding and a
// constant-friendly clog2 helper for derived widths.
package arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b01;
  localparam logic [1:0] ST_GRANT = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT
  } state_e;

  // Ceiling log2; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_n_if.sv
// Request/grant bundle between N bus masters and one arbiter instance.
interface arb_rr_n_if
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               preempt;

  // Requester side.
  modport master (
    output req,
    input  gnt, gnt_valid, gnt_id, preempt
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_id, preempt
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: search req from last_ptr+1 upward with wrap,
// optionally masking one requester out of the search.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_ptr,
  input  logic               excl_valid,
  input  logic [ID_W-1:0]    excl_id,
  output logic               win_valid,
  output logic [ID_W-1:0]    win_id,
  output logic [NUM_REQ-1:0] win_onehot
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    start;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  // Rotate the masked request vector so the search start sits at bit 0, then
  // take the lowest set bit and rotate its index back.
  always_comb begin
    masked = req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (excl_valid && (excl_id == ID_W'(i))) masked[i] = 1'b0;
    end
    start = (last_ptr >= ID_W'(NUM_REQ - 1)) ? '0 : last_ptr + 1'b1;
    rot   = NUM_REQ'({masked, masked} >> start);

    win_valid = 1'b0;
    off       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        win_valid = 1'b1;
        off       = ID_W'(i);
      end
    end

    sum = {1'b0, off} + {1'b0, start};
    if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
    win_id = sum[ID_W-1:0];

    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_onehot[i] = win_valid && (win_id == ID_W'(i));
    end
  end

endmodule

// File: rtl/arb_rr_n.sv
// N-requester round-robin arbiter with registered one-hot grant, owner hold
// while requesting, and a hold limit that forces rotation under contention.
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic       clock,
  input logic       reset,
  arb_rr_n_if.slave bus
);

  localparam int unsigned ID_W = clog2(NUM_REQ);
  localparam int unsigned HC_W = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_ONE = (MAX_HOLD == 0) ? '0 : HC_W'(1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               preempt_q, preempt_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic [ID_W-1:0]    last_q, last_d;

  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_onehot;
  logic               owner_req;
  logic               others;
  logic               take;

  // While granting, the owner is excluded so a forced rotation skips it; when
  // the owner has dropped, excluding it changes nothing.
  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (bus.req),
    .last_ptr   (last_q),
    .excl_valid (state_q == StGrant),
    .excl_id    (gnt_id_q),
    .win_valid  (win_valid),
    .win_id     (win_id),
    .win_onehot (win_onehot)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    last_d    = last_q;
    take      = 1'b0;
    owner_req = |(bus.req & gnt_q);
    others    = |(bus.req & ~gnt_q);

    unique case (state_q)
      StIdle: begin
        if (win_valid) take = 1'b1;
      end
      StGrant: begin
        if (owner_req) begin
          if (others && (MAX_HOLD != 0) && (hold_q == HOLD_MAX)) begin
            take      = 1'b1;
            preempt_d = 1'b1;
          end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
          end
        end else if (win_valid) begin
          take = 1'b1;
        end else begin
          state_d  = StIdle;
          gnt_d    = '0;
          gnt_id_d = '0;
          hold_d   = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
      end
    endcase

    if (take) begin
      state_d  = StGrant;
      gnt_d    = win_onehot;
      gnt_id_d = win_id;
      last_d   = win_id;
      hold_d   = HOLD_ONE;
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      hold_q      <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.preempt   = preempt_q;

  a_gnt_onehot0 : assert property (@(posedge clock) disable iff (!reset) $onehot0(gnt_q));
  a_gnt_valid : assert property (@(posedge clock) disable iff (!reset) gnt_valid_q == |gnt_q);
  a_gnt_id : assert property (@(posedge clock) disable iff (!reset)
    gnt_q == (gnt_valid_q ? (NUM_REQ'(1) << gnt_id_q) : '0));

endmodule

// File: tb/tb_arb_rr_n.sv
// Scoreboard bench for arb_rr_n: two instances (hold limit 4 and unlimited),
// directed request vectors with hand-computed grant expectations.
module tb_arb_rr_n;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  arb_rr_n_if #(.NUM_REQ(4)) bus_a ();
  arb_rr_n_if #(.NUM_REQ(4)) bus_b ();

  arb_rr_n #(.NUM_REQ(4), .MAX_HOLD(4)) u_a (.clock(clock), .reset(reset), .bus(bus_a));
  arb_rr_n #(.NUM_REQ(4), .MAX_HOLD(0)) u_b (.clock(clock), .reset(reset), .bus(bus_b));

  typedef struct {
    int         cyc;
    bit         sel_b;
    logic [3:0] gnt;
    bit         pre;
    bit         chk_hold;
    int         hold;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_at(input int cyc, input bit sel_b, input logic [3:0] g, input bit pre,
                           input bit ch, input int h);
    exp_t x;
    x.cyc = cyc; x.sel_b = sel_b; x.gnt = g; x.pre = pre; x.chk_hold = ch; x.hold = h;
    q.push_back(x);
  endtask

  // Apply req just after an edge; the response is due on the following edge.
  task automatic drive(input bit sel_b, input logic [3:0] r, input logic [3:0] g, input bit pre,
                       input bit ch = 1'b0, input int h = 0);
    @(posedge clock);
    #1;
    if (sel_b) bus_b.req = r;
    else bus_a.req = r;
    expect_at(edge_cnt + 1, sel_b, g, pre, ch, h);
  endtask

  // Monitor: after each edge, check every expectation due by now.
  always begin
    @(posedge clock);
    edge_cnt++;
    #3;
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      e = q.pop_front();
      if (e.sel_b) begin
        cmp($sformatf("B@%0d gnt", e.cyc), int'(bus_b.gnt), int'(e.gnt));
        cmp($sformatf("B@%0d gnt_valid", e.cyc), int'(bus_b.gnt_valid), int'(|e.gnt));
        cmp($sformatf("B@%0d gnt_id", e.cyc), int'(bus_b.gnt_id), onehot_idx(e.gnt));
        cmp($sformatf("B@%0d preempt", e.cyc), int'(bus_b.preempt), int'(e.pre));
        if (e.chk_hold) cmp($sformatf("B@%0d hold_cnt", e.cyc), int'(u_b.hold_q), e.hold);
      end else begin
        cmp($sformatf("A@%0d gnt", e.cyc), int'(bus_a.gnt), int'(e.gnt));
        cmp($sformatf("A@%0d gnt_valid", e.cyc), int'(bus_a.gnt_valid), int'(|e.gnt));
        cmp($sformatf("A@%0d gnt_id", e.cyc), int'(bus_a.gnt_id), onehot_idx(e.gnt));
        cmp($sformatf("A@%0d preempt", e.cyc), int'(bus_a.preempt), int'(e.pre));
        if (e.chk_hold) cmp($sformatf("A@%0d hold_cnt", e.cyc), int'(u_a.hold_q), e.hold);
      end
    end
  end

  initial begin
    logic [3:0] g;
    reset     = 1'b0;
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;

    // Reset state.
    drive(0, 4'b0000, 4'b0000, 0, 1, 0);
    drive(1, 4'b0000, 4'b0000, 0, 1, 0);
    @(posedge clock);
    #4;
    cmp("rst last_ptr", int'(u_a.last_q), 3);
    @(negedge clock);
    reset = 1'b1;

    // Pick from last_ptr+1 = 0: lowest requester of 1010 wins.
    drive(0, 4'b1010, 4'b0010, 0, 1, 1);
    // Owner drops, other pending: direct switch with no idle bubble.
    drive(0, 4'b1000, 4'b1000, 0, 1, 1);
    drive(0, 4'b0000, 4'b0000, 0);

    // Full contention: each owner gets 4 cycles, then is preempted.
    for (int i = 0; i < 20; i++) begin
      g = 4'b0001 << ((i / 4) % 4);
      drive(0, 4'b1111, g, (i % 4 == 0) && (i > 0), 1, (i % 4) + 1);
    end

    // Owner 0 releases to idle; then 0011 goes to requester 1 since last_ptr=0.
    drive(0, 4'b0000, 4'b0000, 0);
    drive(0, 4'b0011, 4'b0010, 0, 1, 1);
    drive(0, 4'b0000, 4'b0000, 0);

    // Lone requester: no preemption, hold count saturates at 4.
    for (int i = 0; i < 20; i++) begin
      drive(0, 4'b0100, 4'b0100, 0, 1, (i < 4) ? i + 1 : 4);
    end
    // Saturated owner meets a waiter: immediate preemption, search wraps to 0.
    drive(0, 4'b0101, 4'b0001, 1, 1, 1);
    drive(0, 4'b0000, 4'b0000, 0);

    // Asynchronous reset mid-grant.
    drive(0, 4'b0100, 4'b0100, 0, 1, 1);
    @(posedge clock);
    #4;
    reset = 1'b0;
    #1;
    cmp("async rst gnt", int'(bus_a.gnt), 0);
    cmp("async rst gnt_id", int'(bus_a.gnt_id), 0);
    cmp("async rst gnt_valid", int'(bus_a.gnt_valid), 0);
    cmp("async rst preempt", int'(bus_a.preempt), 0);
    bus_a.req = 4'b1111;
    #1;
    reset = 1'b1;
    expect_at(edge_cnt + 1, 0, 4'b0001, 0, 1, 1);
    drive(0, 4'b1111, 4'b0001, 0, 1, 2);
    drive(0, 4'b0000, 4'b0000, 0);

    // Unlimited hold: requester 0 keeps the grant under full contention.
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'b1111, 4'b0001, 0, 1, 0);
    end
    drive(1, 4'b0000, 4'b0000, 0);

    repeat (3) @(posedge clock);
    #5;
    cmp("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
